// File: rtl/fetch_queue.sv
// fetch_queue: owns the PC, fetches from combinational imem and buffers
// instructions in a circular queue, with redirect flush and drained halt.
module fetch_queue #(
    parameter int               XLEN       = 32,
    parameter int               DEPTH      = 4,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter logic [XLEN-1:0]  HALT_INSTR = 'h73
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_rdata,
    input  logic                   A_stall,
    input  logic                   LS_stall,
    output logic                   issue_valid,
    output logic [XLEN-1:0]        issue_instr,
    output logic [XLEN-1:0]        issue_pc,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [AW-1:0] INC  = AW'(1);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(3);

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HALTED
    } state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] pc;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];

    logic is_halt, pop, push, full, drained;

    assign is_halt = (imem_rdata == HALT_INSTR);
    assign full    = (count_q == FULL);
    assign pop     = issue_valid & ~A_stall & ~LS_stall;
    assign push    = (state == FETCH) & ~is_halt & (~full | pop)
                   & ~redirect_valid;
    // Queue empties at this edge: nothing held, or the last entry leaves now.
    assign drained = (count_q == '0) | ((count_q == ONE) & pop);

    assign imem_addr   = pc;
    assign count       = count_q;
    assign halted      = (state == HALTED);
    assign issue_valid = (count_q != '0) & (state != HALTED);
    assign issue_instr = issue_valid ? q_instr[rd_ptr] : '0;
    assign issue_pc    = issue_valid ? q_pc[rd_ptr] : '0;

    always_comb begin
        state_nx = state;
        if (redirect_valid) begin
            state_nx = FETCH;
        end else begin
            unique case (state)
                FETCH:   if (is_halt) state_nx = drained ? HALTED : DRAIN;
                DRAIN:   if (drained) state_nx = HALTED;
                HALTED:  state_nx = HALTED;
                default: state_nx = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            state <= state_nx;
            if (redirect_valid) begin
                pc      <= redirect_pc & PC_ALIGN;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    pc     <= pc + PC_STEP;
                    wr_ptr <= wr_ptr + INC;
                end
                if (pop) rd_ptr <= rd_ptr + INC;
                if (push & ~pop)      count_q <= count_q + ONE;
                else if (pop & ~push) count_q <= count_q - ONE;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based
// reference model of the fetch queue.
module tb_fetch_queue;

    localparam logic [31:0] HALT = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_rdata;
    logic        A_stall, LS_stall;
    logic        issue_valid;
    logic [31:0] issue_instr, issue_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  count;
    logic        halted;

    logic [31:0] imem [256];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_seen;
    bit          m_halted;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr[9:2]];

    fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .A_stall        (A_stall),
        .LS_stall       (LS_stall),
        .issue_valid    (issue_valid),
        .issue_instr    (issue_instr),
        .issue_pc       (issue_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .count          (count),
        .halted         (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_imem(input bit rnd);
        for (int i = 0; i < 256; i++) begin
            imem[i] = rnd ? $urandom : (32'h0000_0093 | (i << 20));
            if (imem[i] == HALT) imem[i] = 32'h13;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc     = 32'h0;
        m_seen   = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic step(input logic a, input logic ls, input logic rv,
                        input logic [31:0] rp);
        bit   exp_v, pop;
        int   sz;
        ent_t e;
        A_stall        = a;
        LS_stall       = ls;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
        exp_v = (q.size() != 0) && !m_halted;
        check("issue_valid", {31'b0, issue_valid}, {31'b0, exp_v});
        check("count", {29'b0, count}, 32'(q.size()));
        check("imem_addr", imem_addr, m_pc);
        check("halted", {31'b0, halted}, {31'b0, m_halted});
        if (exp_v) begin
            check("issue_pc", issue_pc, q[0].pc);
            check("issue_instr", issue_instr, q[0].instr);
        end
        pop = exp_v && !a && !ls;
        @(posedge clk);
        if (rv) begin
            q.delete();
            m_pc     = rp & ~32'h3;
            m_seen   = 1'b0;
            m_halted = 1'b0;
        end else begin
            sz = q.size();
            if (pop) void'(q.pop_front());
            if (!m_seen && !m_halted) begin
                if (imem[m_pc[9:2]] == HALT) begin
                    m_seen = 1'b1;
                end else if (sz < 4 || pop) begin
                    e.instr = imem[m_pc[9:2]];
                    e.pc    = m_pc;
                    q.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
            if (m_seen && q.size() == 0) begin
                m_seen   = 1'b0;
                m_halted = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b0;
        A_stall        = 1'b0;
        LS_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fill_imem(0);
        imem[4] = HALT;
        model_reset();

        #2;
        check("rst_valid", {31'b0, issue_valid}, 32'h0);
        check("rst_count", {29'b0, count}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_instr", issue_instr, 32'h0);
        check("rst_pc", issue_pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Straight-line program ending in HALT at 0x10
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        check("t1_halted", {31'b0, halted}, 32'h1);

        // Long arithmetic stall fills the queue, then release
        fill_imem(0);
        step(0, 0, 1, 32'h0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        check("t2_full", {29'b0, count}, 32'd4);
        check("t2_pc_frozen", imem_addr, 32'h10);
        check("t2_head", issue_pc, 32'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        check("t2_refill", {29'b0, count}, 32'd4);

        // Redirect to a misaligned target with three entries queued
        step(0, 0, 1, 32'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        check("t4_pre", {29'b0, count}, 32'd3);
        step(1, 0, 1, 32'h41);
        check("t4_count", {29'b0, count}, 32'd0);
        check("t4_valid", {31'b0, issue_valid}, 32'h0);
        check("t4_addr", imem_addr, 32'h40);
        step(0, 0, 0, 0);
        check("t4_head", issue_pc, 32'h40);

        // HALT seen with two entries held by a load/store stall
        imem[8'h88 >> 2] = HALT;
        step(0, 0, 1, 32'h80);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        check("t5_count", {29'b0, count}, 32'd2);
        check("t5_not_halted", {31'b0, halted}, 32'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("t5_halted", {31'b0, halted}, 32'h1);
        step(0, 0, 1, 32'h20);
        check("t5_resume_h", {31'b0, halted}, 32'h0);
        check("t5_resume_pc", imem_addr, 32'h20);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // Reset mid-drain with three entries queued
        fill_imem(0);
        imem[3] = HALT;
        step(0, 0, 1, 32'h0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        check("t6_pre", {29'b0, count}, 32'd3);
        #2 reset = 1'b0;
        #1;
        check("t6_valid", {31'b0, issue_valid}, 32'h0);
        check("t6_count", {29'b0, count}, 32'h0);
        check("t6_pc", imem_addr, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

        // Random stalls, redirects and sparse HALT words
        fill_imem(1);
        for (int i = 0; i < 256; i++)
            if ($urandom_range(0, 39) == 0) imem[i] = HALT;
        step(0, 0, 1, 32'h0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 24) == 0, 32'($urandom_range(0, 1023)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
